pwm_capture: RTL

- Receive-side counterpart of the team's PWM LED generator.
- Samples an external PWM waveform, synchronises it, and measures high time and period in clk cycles.
- Reports each completed measurement with a one-cycle valid strobe.
- Used for loop-back self-test of the PWM outputs and as a duty-cycle input path on the tile.

---
 rtl/pwm_capture_pkg.sv | 12 +
 rtl/pwm_capture_sync.sv | 33 +++
 rtl/pwm_capture.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_capture_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, ARM, MEAS_HI, MEAS_LO} state_e;

  function automatic int cnt_max(input int w);
    return int'((64'(1) << w) - 64'(1));
  endfunction

endpackage

// File: rtl/pwm_capture_sync.sv
// Input synchroniser and edge detector for the PWM capture block.
module pwm_capture_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   pwm_d;

  // Edge flags are registered; pwm_d is the level that lines up with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
      pwm_d <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pwm_in};
      pwm_d <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~pwm_d;
      fall  <= ~chain[SYNC_STAGES-1] & pwm_d;
    end
  end

  assign pwm_s = pwm_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input.
// Optional PWM_CAPTURE_AVG_EN: reports the average of every 4 measurements.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             pwm_s, rise, fall;
  state_e           state;
  logic [CNT_W-1:0] hi_cnt, per_cnt, hi_inc, per_inc;
  logic             end_edge, timeout;

  pwm_capture_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .pwm_s  (pwm_s),
    .rise   (rise),
    .fall   (fall)
  );

  assign hi_inc  = (hi_cnt  == CNT_MAX) ? hi_cnt  : hi_cnt  + CNT_W'(1);
  assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_W'(1);

  always_comb begin
    end_edge = 1'b0;
    case (state)
      ARM, MEAS_LO: end_edge = rise;
      MEAS_HI:      end_edge = fall;
      default:      end_edge = 1'b0;
    endcase
  end

  // A terminating edge on the saturation cycle wins over the timeout.
  assign timeout = (state != IDLE) && (per_cnt == CNT_MAX) && !end_edge;

`ifdef PWM_CAPTURE_AVG_EN
  logic [CNT_W+1:0] sum_hi, sum_per, sum_hi_nxt, sum_per_nxt;
  logic [1:0]       n_meas;

  assign sum_hi_nxt  = sum_hi  + (CNT_W+2)'(hi_cnt);
  assign sum_per_nxt = sum_per + (CNT_W+2)'(per_cnt);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hi_cnt    <= '0;
      per_cnt   <= '0;
      high_time <= '0;
      period    <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
`ifdef PWM_CAPTURE_AVG_EN
      sum_hi    <= '0;
      sum_per   <= '0;
      n_meas    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state   <= IDLE;
        hi_cnt  <= '0;
        per_cnt <= '0;
`ifdef PWM_CAPTURE_AVG_EN
        sum_hi  <= '0;
        sum_per <= '0;
        n_meas  <= '0;
`endif
      end else if (timeout) begin
        valid     <= 1'b1;
        stuck     <= 1'b1;
        period    <= CNT_MAX;
        high_time <= pwm_s ? CNT_MAX : '0;
        hi_cnt    <= '0;
        per_cnt   <= '0;
        state     <= ARM;
`ifdef PWM_CAPTURE_AVG_EN
        sum_hi    <= '0;
        sum_per   <= '0;
        n_meas    <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            hi_cnt  <= '0;
            per_cnt <= '0;
            state   <= ARM;
          end
          ARM: begin
            if (rise) begin
              hi_cnt  <= CNT_W'(1);
              per_cnt <= CNT_W'(1);
              state   <= MEAS_HI;
            end else begin
              per_cnt <= per_inc;
            end
          end
          MEAS_HI: begin
            per_cnt <= per_inc;
            if (fall)       state  <= MEAS_LO;
            else if (pwm_s) hi_cnt <= hi_inc;
          end
          MEAS_LO: begin
            if (rise) begin
`ifdef PWM_CAPTURE_AVG_EN
              if (n_meas == 2'd3) begin
                valid     <= 1'b1;
                stuck     <= 1'b0;
                high_time <= sum_hi_nxt[CNT_W+1:2];
                period    <= sum_per_nxt[CNT_W+1:2];
                sum_hi    <= '0;
                sum_per   <= '0;
                n_meas    <= '0;
              end else begin
                sum_hi    <= sum_hi_nxt;
                sum_per   <= sum_per_nxt;
                n_meas    <= n_meas + 2'd1;
              end
`else
              valid     <= 1'b1;
              stuck     <= 1'b0;
              high_time <= hi_cnt;
              period    <= per_cnt;
`endif
              hi_cnt  <= CNT_W'(1);
              per_cnt <= CNT_W'(1);
              state   <= MEAS_HI;
            end else begin
              per_cnt <= per_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
